sample_hysteresis_detector: RTL
===============================

# sample_hysteresis_detector

Downstream consumer of the 3-tap moving-average stage. It takes the signed 8-bit smoothed sample stream, applies a hysteresis comparator with a consecutive-sample debounce, and reports a stable level. Each debounced crossing produces a one-cycle rise or fall pulse, and a saturating counter tracks crossing events. Its outputs feed the control and telemetry logic behind the averaging filter.

## Interface
- DEBOUNCE, 3: consecutive qualifying valid samples needed to change level. Legal range 1..15.
- CNT_W, 16: width of the crossing-event counter.
- system1000 in 1: clock; all logic on the rising edge.
- system1000_rstn in 1: reset, synchronous, active-low.
- avg_i in 8 signed: smoothed sample from the moving-average stage.
- avg_valid_i in 1: avg_i carries a new sample this cycle.
- thr_hi_i in 8 signed: rising threshold; a sample qualifies when it is >= thr_hi_i.
- thr_lo_i in 8 signed: falling threshold; a sample qualifies when it is <= thr_lo_i.
- level_o out 1: debounced level (1 = high region).
- rise_o out 1: one-cycle pulse on a debounced low-to-high change.
- fall_o out 1: one-cycle pulse on a debounced high-to-low change.
- edge_count_o out CNT_W: saturating count of rise plus fall events.
- cfg_err_o out 1: thr_lo_i > thr_hi_i.
- min_o / max_o out 8 signed: extremes of the valid samples (see Configuration).

## Operation
- All comparisons are signed 8-bit. Thresholds are sampled together with each valid sample; they are not latched.
- FSM states: INIT, LOW, RISE_PEND, HIGH, FALL_PEND. Reset state is INIT.
- INIT: on the first valid sample, go to HIGH if the sample is >= thr_hi_i, otherwise go to LOW. This initial classification produces no pulse and no count.
- LOW: a qualifying sample sets the debounce count to 1.
  - If DEBOUNCE = 1, go directly to HIGH and rise.
  - Otherwise go to RISE_PEND.
- RISE_PEND:
  - A qualifying sample increments the count. When the count reaches DEBOUNCE, go to HIGH, pulse rise_o and clear the count.
  - A non-qualifying valid sample returns to LOW and clears the count.
- HIGH and FALL_PEND mirror LOW and RISE_PEND, using thr_lo_i and fall_o.
- Cycles with avg_valid_i = 0 hold the state and the count. Invalid cycles do not break a debounce run.
- Samples strictly between the thresholds never qualify, so they hold LOW/HIGH and cancel any pending transition.
- cfg_err_o = (thr_lo_i > thr_hi_i), combinational.
  - While it is asserted, valid samples are ignored: state, count and outputs hold.
  - thr_lo_i == thr_hi_i is legal and means zero hysteresis.
- edge_count_o increments on every rise or fall and saturates at 2^CNT_W-1 with no wrap.
- level_o is 1 in HIGH and FALL_PEND, 0 otherwise.

## Timing
- All outputs except cfg_err_o are registered.
- Reset values: level_o=0, rise_o=0, fall_o=0, edge_count_o=0, min_o=0, max_o=0, state INIT, debounce count 0.
- Latency: if the DEBOUNCE-th qualifying sample is presented at edge k, then level_o, rise_o/fall_o and edge_count_o update after edge k. The pulse is high for exactly the cycle between edges k and k+1.
- At most one of rise_o or fall_o is high in any cycle.
- Reset takes priority over avg_valid_i on the same edge. Reset mid-debounce discards the pending run and returns to INIT.

## Configuration
- Macro: SAMPLE_HYSTERESIS_DETECTOR_MINMAX_EN.
- Defined:
  - min_o and max_o track the minimum and maximum of valid samples since reset.
  - The first valid sample after reset loads both registers.
  - Updates are registered and appear one edge after the sample.
  - Samples taken while cfg_err_o is asserted are still tracked.
- Undefined:
  - No tracking registers are built.
  - min_o and max_o are driven constant 0.

## Structure
- Package sample_hysteresis_detector_types holds:
  - sample_t (logic signed [7:0]);
  - the state enum (INIT, LOW, RISE_PEND, HIGH, FALL_PEND);
  - DEBOUNCE_W = 4.
- One natural sub-module, hyst_debounce_cnt: it implements the clear/increment/terminal-count logic and is instantiated once, shared by both pending states.
- The FSM, saturating counter and optional min/max registers live in the top module.

## Test plan
Common settings: DEBOUNCE=3, thr_hi_i=20, thr_lo_i=-20, valid asserted unless noted.
1. Initial classification: reset, then first valid sample 30 -> level_o=1 after that edge, no rise_o, edge_count_o=0.
2. Clean rise from LOW: samples 25,25,25 -> rise_o high for one cycle after the third edge, level_o=1, edge_count_o=1.
3. Bounce cancels: from LOW, samples 25,25,10,25,25 -> no rise_o; a third consecutive 25 is then required before the rise.
4. Invalid gaps do not break a run: 25, two invalid cycles carrying avg_i=-100, 25, 25 -> rise after the third valid sample.
5. Hysteresis band: in HIGH, samples alternating -19 and 19 -> level_o stays 1. Then -20,-20,-20 -> fall_o pulse, edge_count_o increments.
6. Config error and saturation:
   - thr_lo_i=30 with thr_hi_i=20 -> cfg_err_o=1, no transitions on any input.
   - With CNT_W=2, five alternating debounced crossings -> edge_count_o stops at 3.

Source files
------------

// File: rtl/sample_hysteresis_detector_pkg.sv
// Shared types for the sample hysteresis detector: sample type, FSM states and
// the width of the debounce run counter.
package sample_hysteresis_detector_types;

   localparam int unsigned DEBOUNCE_W = 4;

   typedef logic signed [7:0] sample_t;

   typedef enum logic [2:0] {
      INIT,
      LOW,
      RISE_PEND,
      HIGH,
      FALL_PEND
   } state_t;

endpackage

// File: rtl/sample_hysteresis_detector_hyst_debounce_cnt.sv
// Debounce run counter shared by both pending states: counts qualifying
// samples and flags the one that completes a run of DEBOUNCE.
module hyst_debounce_cnt
   import sample_hysteresis_detector_types::*;
#(
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic terminal_c
);

   localparam logic [DEBOUNCE_W-1:0] LAST = DEBOUNCE_W'(DEBOUNCE - 1);

   logic [DEBOUNCE_W-1:0] count;

   // The qualifying sample that brings the run to DEBOUNCE is the terminal one.
   assign terminal_c = inc && (count >= LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr || terminal_c) begin
         count <= '0;
      end else if (inc) begin
         count <= count + DEBOUNCE_W'(1);
      end
   end

endmodule

// File: rtl/sample_hysteresis_detector.sv
// Hysteresis comparator with consecutive-sample debounce on the smoothed stream.
// Optional min/max tracking is built when SAMPLE_HYSTERESIS_DETECTOR_MINMAX_EN is defined.
module sample_hysteresis_detector
   import sample_hysteresis_detector_types::*;
#(
   parameter int unsigned DEBOUNCE = 3,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               system1000,
   input  logic               system1000_rstn,
   input  logic signed [7:0]  avg_i,
   input  logic               avg_valid_i,
   input  logic signed [7:0]  thr_hi_i,
   input  logic signed [7:0]  thr_lo_i,
   output logic               level_o,
   output logic               rise_o,
   output logic               fall_o,
   output logic [CNT_W-1:0]   edge_count_o,
   output logic               cfg_err_o,
   output logic signed [7:0]  min_o,
   output logic signed [7:0]  max_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   logic   sample_ev_c;
   logic   qual_hi_c;
   logic   qual_lo_c;
   logic   inc_c;
   logic   clr_c;
   logic   terminal_c;
   logic   crossing_c;

   assign cfg_err_o   = (thr_lo_i > thr_hi_i);
   assign sample_ev_c = avg_valid_i && !cfg_err_o;
   assign qual_hi_c   = (avg_i >= thr_hi_i);
   assign qual_lo_c   = (avg_i <= thr_lo_i);

   // A sample advances the run only if it qualifies toward the opposite level.
   always_comb begin
      inc_c = 1'b0;
      case (state)
         LOW, RISE_PEND:  inc_c = sample_ev_c && qual_hi_c;
         HIGH, FALL_PEND: inc_c = sample_ev_c && qual_lo_c;
         default:         inc_c = 1'b0;
      endcase
   end

   assign clr_c      = sample_ev_c && !inc_c;
   assign crossing_c = terminal_c;

   hyst_debounce_cnt #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk        (system1000),
      .rst_n      (system1000_rstn),
      .clr        (clr_c),
      .inc        (inc_c),
      .terminal_c (terminal_c)
   );

   always_ff @(posedge system1000) begin
      if (!system1000_rstn) begin
         state        <= INIT;
         level_o      <= 1'b0;
         rise_o       <= 1'b0;
         fall_o       <= 1'b0;
         edge_count_o <= '0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         if (crossing_c && (edge_count_o != CNT_MAX)) begin
            edge_count_o <= edge_count_o + CNT_W'(1);
         end
         if (sample_ev_c) begin
            case (state)
               INIT: begin
                  // First sample only classifies the level; no pulse, no count.
                  if (qual_hi_c) begin
                     state   <= HIGH;
                     level_o <= 1'b1;
                  end else begin
                     state   <= LOW;
                     level_o <= 1'b0;
                  end
               end
               LOW, RISE_PEND: begin
                  if (terminal_c) begin
                     state   <= HIGH;
                     level_o <= 1'b1;
                     rise_o  <= 1'b1;
                  end else if (qual_hi_c) begin
                     state <= RISE_PEND;
                  end else begin
                     state <= LOW;
                  end
               end
               HIGH, FALL_PEND: begin
                  if (terminal_c) begin
                     state   <= LOW;
                     level_o <= 1'b0;
                     fall_o  <= 1'b1;
                  end else if (qual_lo_c) begin
                     state <= FALL_PEND;
                  end else begin
                     state <= HIGH;
                  end
               end
               default: begin
                  state   <= INIT;
                  level_o <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SAMPLE_HYSTERESIS_DETECTOR_MINMAX_EN
   logic seen;

   // Extremes follow every valid sample, including those taken during cfg_err_o.
   always_ff @(posedge system1000) begin
      if (!system1000_rstn) begin
         seen  <= 1'b0;
         min_o <= '0;
         max_o <= '0;
      end else if (avg_valid_i) begin
         seen <= 1'b1;
         if (!seen || (avg_i < min_o)) begin
            min_o <= avg_i;
         end
         if (!seen || (avg_i > max_o)) begin
            max_o <= avg_i;
         end
      end
   end
`else
   assign min_o = '0;
   assign max_o = '0;
`endif

endmodule
